chain_dp_max: RTL and testbench



---
 rtl/chain_pkg.sv | 32 +++
 rtl/chain_dp_max_if.sv | 37 +++
 rtl/chain_sat_add.sv | 23 ++
 rtl/chain_dp_max.sv | 221 ++++++++++++++++++++++
 tb/tb_chain_dp_max.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/chain_pkg.sv
// Shared definitions for the chaining DP stages: default widths, the
// no-predecessor marker, FSM state encoding and a saturating signed add.
package chain_pkg;

    localparam int unsigned CHAIN_DATA_W = 32;
    localparam int unsigned CHAIN_IDX_W  = 16;

    localparam logic [CHAIN_IDX_W-1:0] NO_PRED = {CHAIN_IDX_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } chain_state_e;

    // Signed add of two CHAIN_DATA_W values, clamped to the signed range
    function automatic logic [CHAIN_DATA_W-1:0] sat_add(
        input logic [CHAIN_DATA_W-1:0] a,
        input logic [CHAIN_DATA_W-1:0] b
    );
        logic [CHAIN_DATA_W:0] ext;
        ext = {a[CHAIN_DATA_W-1], a} + {b[CHAIN_DATA_W-1], b};
        if (ext[CHAIN_DATA_W] != ext[CHAIN_DATA_W-1]) begin
            sat_add = ext[CHAIN_DATA_W] ? {1'b1, {(CHAIN_DATA_W-1){1'b0}}}
                                        : {1'b0, {(CHAIN_DATA_W-1){1'b1}}};
        end else begin
            sat_add = ext[CHAIN_DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/chain_dp_max_if.sv
// Candidate-in / result-out stream bundle for chain_dp_max.
interface chain_dp_max_if
    import chain_pkg::*;
#(
    parameter int unsigned DATA_W = CHAIN_DATA_W,
    parameter int unsigned IDX_W  = CHAIN_IDX_W
);
    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic              in_last;
    logic              in_skip;
    logic [DATA_W-1:0] in_w;
    logic [IDX_W-1:0]  in_i;
    logic [IDX_W-1:0]  in_j;
    logic [DATA_W-1:0] in_score;
    logic [DATA_W-1:0] in_fj;

    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_i;
    logic [DATA_W-1:0] out_f;
    logic [IDX_W-1:0]  out_p;
    logic              out_has_pred;

    modport slave (
        input  in_valid, in_first, in_last, in_skip, in_w, in_i, in_j,
               in_score, in_fj, out_ready,
        output in_ready, out_valid, out_i, out_f, out_p, out_has_pred
    );

    modport master (
        output in_valid, in_first, in_last, in_skip, in_w, in_i, in_j,
               in_score, in_fj, out_ready,
        input  in_ready, out_valid, out_i, out_f, out_p, out_has_pred
    );
endinterface

// File: rtl/chain_sat_add.sv
// Combinational signed add with one guard bit, saturated to DATA_W.
module chain_sat_add #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_sum_c
);
    localparam int unsigned EXT_W = DATA_W + 1;

    logic [EXT_W-1:0] w_ext;

    assign w_ext = {i_a[DATA_W-1], i_a} + {i_b[DATA_W-1], i_b};

    // Clamp when the guard bit disagrees with the sign bit
    always_comb begin
        o_sum_c = w_ext[DATA_W-1:0];
        if (w_ext[DATA_W] != w_ext[DATA_W-1]) begin
            o_sum_c = w_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/chain_dp_max.sv
// Chaining DP max stage: folds one anchor's candidate stream into
// f[i] = max(W_i, max_j(f[j] + sc(i,j))) and the best predecessor p[i].
// Optional early termination after MAX_SKIP non-improving candidates is
// enabled by defining CHAIN_MAX_SKIP_EN.
module chain_dp_max
    import chain_pkg::*;
#(
    parameter int unsigned DATA_W   = CHAIN_DATA_W,
    parameter int unsigned IDX_W    = CHAIN_IDX_W,
    parameter int unsigned MAX_SKIP = 25,
    parameter int unsigned SKIP_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    chain_dp_max_if.slave        bus,
    output logic                 proto_err
);
    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_ACCUM = 2'(ACCUM);
    localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
    localparam logic [1:0] ST_OUT   = 2'(OUT);

    logic [1:0]        r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [IDX_W-1:0]  r_out_i;
    logic [DATA_W-1:0] r_out_f;
    logic [IDX_W-1:0]  r_out_p;
    logic              r_out_has;
    logic [IDX_W-1:0]  r_i;
    logic [DATA_W-1:0] r_best_f;
    logic [IDX_W-1:0]  r_best_p;
    logic              r_has_pred;
    logic              r_proto_err;

    logic [1:0]        w_state_nx;
    logic [IDX_W-1:0]  w_i_nx;
    logic [DATA_W-1:0] w_best_f_nx;
    logic [IDX_W-1:0]  w_best_p_nx;
    logic              w_has_nx;
    logic              w_proto_nx;
    logic [DATA_W-1:0] w_base_f;
    logic [IDX_W-1:0]  w_base_p;
    logic              w_base_has;
    logic              w_xfer;
    logic              w_load;
    logic              w_cmp;
    logic              w_improve;
    logic [DATA_W-1:0] w_sum;

`ifdef CHAIN_MAX_SKIP_EN
    logic [SKIP_W-1:0] r_skip_cnt;
    logic [SKIP_W-1:0] w_skip_base;
    logic [SKIP_W-1:0] w_skip_nx;
`else
    logic              w_unused_cfg;
    assign w_unused_cfg = ^{32'(MAX_SKIP), 32'(SKIP_W), ST_DRAIN};
`endif

    assign w_xfer = bus.in_valid && r_in_ready;

    chain_sat_add #(.DATA_W(DATA_W)) u_sat_add (
        .i_a     (bus.in_fj),
        .i_b     (bus.in_score),
        .o_sum_c (w_sum)
    );

    // Next-state, candidate compare and next best-value computation
    always_comb begin
        w_state_nx  = r_state;
        w_i_nx      = r_i;
        w_proto_nx  = r_proto_err;
        w_load      = 1'b0;
        w_cmp       = 1'b0;
        w_base_f    = r_best_f;
        w_base_p    = r_best_p;
        w_base_has  = r_has_pred;
        w_improve   = 1'b0;
        w_best_f_nx = r_best_f;
        w_best_p_nx = r_best_p;
        w_has_nx    = r_has_pred;
`ifdef CHAIN_MAX_SKIP_EN
        w_skip_base = r_skip_cnt;
        w_skip_nx   = r_skip_cnt;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (bus.in_first) begin
                        w_load = 1'b1;
                        w_cmp  = 1'b1;
                    end else begin
                        w_proto_nx = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (w_xfer) begin
                    w_cmp = 1'b1;
                    if (bus.in_first) begin
                        w_load     = 1'b1;
                        w_proto_nx = 1'b1;
                    end
                end
            end
`ifdef CHAIN_MAX_SKIP_EN
            ST_DRAIN: begin
                if (w_xfer) begin
                    if (bus.in_first) begin
                        w_load     = 1'b1;
                        w_cmp      = 1'b1;
                        w_proto_nx = 1'b1;
                    end else if (bus.in_last) begin
                        w_state_nx = ST_OUT;
                    end
                end
            end
`endif
            ST_OUT: begin
                if (bus.out_ready) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_i_nx     = bus.in_i;
            w_base_f   = bus.in_w;
            w_base_p   = {IDX_W{1'b1}};
            w_base_has = 1'b0;
`ifdef CHAIN_MAX_SKIP_EN
            w_skip_base = '0;
`endif
        end

        w_improve   = w_cmp && !bus.in_skip && ($signed(w_sum) > $signed(w_base_f));
        w_best_f_nx = w_improve ? w_sum    : w_base_f;
        w_best_p_nx = w_improve ? bus.in_j : w_base_p;
        w_has_nx    = w_improve ? 1'b1     : w_base_has;

`ifdef CHAIN_MAX_SKIP_EN
        w_skip_nx = w_skip_base;
        if (w_cmp && !bus.in_skip) begin
            if (w_improve) begin
                w_skip_nx = '0;
            end else if (w_skip_base != {SKIP_W{1'b1}}) begin
                w_skip_nx = w_skip_base + SKIP_W'(1);
            end
        end
`endif

        if (w_cmp) begin
            if (bus.in_last) begin
                w_state_nx = ST_OUT;
`ifdef CHAIN_MAX_SKIP_EN
            end else if (w_skip_nx >= SKIP_W'(MAX_SKIP)) begin
                w_state_nx = ST_DRAIN;
`endif
            end else begin
                w_state_nx = ST_ACCUM;
            end
        end
    end

    // State, best-value and registered output updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_i     <= '0;
            r_out_f     <= '0;
            r_out_p     <= {IDX_W{1'b1}};
            r_out_has   <= 1'b0;
            r_i         <= '0;
            r_best_f    <= '0;
            r_best_p    <= {IDX_W{1'b1}};
            r_has_pred  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_in_ready  <= (w_state_nx != ST_OUT);
            r_out_valid <= (w_state_nx == ST_OUT);
            r_i         <= w_i_nx;
            r_best_f    <= w_best_f_nx;
            r_best_p    <= w_best_p_nx;
            r_has_pred  <= w_has_nx;
            r_proto_err <= w_proto_nx;
            if ((w_state_nx == ST_OUT) && (r_state != ST_OUT)) begin
                r_out_i   <= w_i_nx;
                r_out_f   <= w_best_f_nx;
                r_out_p   <= w_best_p_nx;
                r_out_has <= w_has_nx;
            end
        end
    end

`ifdef CHAIN_MAX_SKIP_EN
    // Consecutive non-improving candidate counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skip_cnt <= '0;
        end else begin
            r_skip_cnt <= w_skip_nx;
        end
    end
`endif

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_i        = r_out_i;
    assign bus.out_f        = r_out_f;
    assign bus.out_p        = r_out_p;
    assign bus.out_has_pred = r_out_has;
    assign proto_err        = r_proto_err;

endmodule

// File: tb/tb_chain_dp_max.sv
// Scoreboard bench for chain_dp_max. Expected results come from a
// per-beat reference model and are popped when a result handshakes.
module tb_chain_dp_max;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned IDX_W    = 16;
    localparam int unsigned MAX_SKIP = 3;

    typedef struct {
        logic [IDX_W-1:0]  i;
        logic [DATA_W-1:0] f;
        logic [IDX_W-1:0]  p;
        logic              has;
    } exp_t;

    logic clk;
    logic reset;
    logic proto_err;

    chain_dp_max_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) ifc ();

    chain_dp_max #(
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .MAX_SKIP (MAX_SKIP),
        .SKIP_W   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (ifc.slave),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_pushed  = 0;
    int   n_popped  = 0;
    exp_t sb[$];

    // Reference model state
    logic              m_active = 1'b0;
    logic              m_drain  = 1'b0;
    longint            m_f      = 0;
    logic [IDX_W-1:0]  m_p      = '1;
    logic              m_has    = 1'b0;
    logic [IDX_W-1:0]  m_i      = '0;
    int                m_cnt    = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply the recurrence to one beat as the bench understands it
    task automatic model_beat(input logic first, input logic last, input logic skip,
                              input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] i,
                              input logic [IDX_W-1:0] j, input logic [DATA_W-1:0] sc,
                              input logic [DATA_W-1:0] fj);
        longint s;
        exp_t   e;
        if (first) begin
            m_active = 1'b1;
            m_drain  = 1'b0;
            m_f      = longint'($signed(w));
            m_p      = '1;
            m_has    = 1'b0;
            m_i      = i;
            m_cnt    = 0;
        end
        if (!m_active) return;
        if (!m_drain && !skip) begin
            s = longint'($signed(fj)) + longint'($signed(sc));
            if (s > 64'sd2147483647)  s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
            if (s > m_f) begin
                m_f   = s;
                m_p   = j;
                m_has = 1'b1;
                m_cnt = 0;
            end else begin
`ifdef CHAIN_MAX_SKIP_EN
                if (m_cnt < 255) m_cnt++;
                if (m_cnt >= int'(MAX_SKIP) && !last) m_drain = 1'b1;
`endif
            end
        end
        if (last) begin
            e.i   = m_i;
            e.f   = 32'(m_f);
            e.p   = m_p;
            e.has = m_has;
            sb.push_back(e);
            n_pushed++;
            m_active = 1'b0;
        end
    endtask

    // Drive one beat, wait for acceptance, then check result latency
    task automatic send_beat(input logic first, input logic last, input logic skip,
                             input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] i,
                             input logic [IDX_W-1:0] j, input logic [DATA_W-1:0] sc,
                             input logic [DATA_W-1:0] fj);
        int  n = 0;
        logic completes;
        @(negedge clk);
        while (!ifc.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.in_ready) begin
            check("in_ready_timeout", ifc.in_ready, 1);
            return;
        end
        completes = last && (first || m_active);
        ifc.in_valid = 1'b1;
        ifc.in_first = first;
        ifc.in_last  = last;
        ifc.in_skip  = skip;
        ifc.in_w     = w;
        ifc.in_i     = i;
        ifc.in_j     = j;
        ifc.in_score = sc;
        ifc.in_fj    = fj;
        model_beat(first, last, skip, w, i, j, sc, fj);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_first = 1'b0;
        ifc.in_last  = 1'b0;
        ifc.in_skip  = 1'b0;
        if (completes) begin
            @(negedge clk);
            check("latency_out_valid", ifc.out_valid, 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pop and compare whenever a result handshakes
    always @(negedge clk) begin
        exp_t e;
        if (!reset && ifc.out_valid && ifc.out_ready) begin
            check("sb_has_entry", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_popped++;
                check("out_i", ifc.out_i, e.i);
                check("out_f", ifc.out_f, e.f);
                check("out_p", ifc.out_p, e.p);
                check("out_has_pred", ifc.out_has_pred, e.has);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  ifc.in_ready, 1);
        check({tag, "_out_valid"}, ifc.out_valid, 0);
        check({tag, "_out_i"},     ifc.out_i, 0);
        check({tag, "_out_f"},     ifc.out_f, 0);
        check({tag, "_out_p"},     ifc.out_p, 16'hFFFF);
        check({tag, "_has_pred"},  ifc.out_has_pred, 0);
        check({tag, "_proto_err"}, proto_err, 0);
    endtask

    initial begin
        reset        = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_first = 1'b0;
        ifc.in_last  = 1'b0;
        ifc.in_skip  = 1'b0;
        ifc.in_w     = '0;
        ifc.in_i     = '0;
        ifc.in_j     = '0;
        ifc.in_score = '0;
        ifc.in_fj    = '0;
        ifc.out_ready = 1'b1;
        idle(3);
        check_reset_values("rst");
        reset = 1'b0;
        idle(2);

        // Basic anchor under 4 cycles of backpressure: expect f=55, p=2
        @(posedge clk); #1 ifc.out_ready = 1'b0;
        send_beat(1, 0, 0, 32'd15, 16'd5, 16'd4, -32'sd3,  32'd40);
        send_beat(0, 0, 0, 32'd15, 16'd5, 16'd3, -32'sd20, 32'd50);
        send_beat(0, 1, 0, 32'd15, 16'd5, 16'd2, -32'sd5,  32'd60);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_out_valid", ifc.out_valid, 1);
            check("bp_in_ready", ifc.in_ready, 0);
            check("bp_out_f", ifc.out_f, 32'd55);
            check("bp_out_p", ifc.out_p, 16'd2);
        end
        @(posedge clk); #1 ifc.out_ready = 1'b1;
        idle(2);

        // Tie keeps the earlier candidate (p=7)
        send_beat(1, 0, 0, 32'd10, 16'd8, 16'd7, 32'd0, 32'd20);
        send_beat(0, 1, 0, 32'd10, 16'd8, 16'd6, 32'd1, 32'd19);
        idle(2);

        // All in_skip beats: f=W, no predecessor
        send_beat(1, 0, 1, 32'd30, 16'd9, 16'd8, 32'd500, 32'd500);
        send_beat(0, 1, 1, 32'd30, 16'd9, 16'd7, 32'd500, 32'd500);
        // Sum not above W
        send_beat(1, 1, 0, 32'd30, 16'd10, 16'd9, 32'd5, 32'd10);
        // Positive saturation
        send_beat(1, 1, 0, 32'd0, 16'd11, 16'd10, 32'h100, 32'h7FFF_FFF0);
        idle(2);

        // Beat without first in IDLE is dropped and flagged
        send_beat(0, 0, 0, 32'd1, 16'd99, 16'd98, 32'd1, 32'd1);
        @(negedge clk);
        check("proto_err_no_first", proto_err, 1);
        // First mid-anchor restarts; only anchor 21 reports (f=31, p=20)
        send_beat(1, 0, 0, 32'd5, 16'd20, 16'd19, 32'd0,    32'd50);
        send_beat(1, 0, 0, 32'd5, 16'd21, 16'd20, 32'd1,    32'd30);
        send_beat(0, 1, 0, 32'd5, 16'd21, 16'd19, -32'sd20, 32'd40);
        @(negedge clk);
        check("proto_err_sticky", proto_err, 1);
        idle(2);

        // Early-termination pattern: candidate 5 wins only without the skip limit
        send_beat(1, 0, 0, 32'd0, 16'd30, 16'd10, 32'd0, 32'd100);
        send_beat(0, 0, 0, 32'd0, 16'd30, 16'd9,  32'd0, 32'd50);
        send_beat(0, 0, 0, 32'd0, 16'd30, 16'd8,  32'd0, 32'd50);
        send_beat(0, 0, 0, 32'd0, 16'd30, 16'd7,  32'd0, 32'd50);
        send_beat(0, 1, 0, 32'd0, 16'd30, 16'd6,  32'd0, 32'd200);
        idle(2);

        // Reset in the middle of an anchor discards it
        send_beat(1, 0, 0, 32'd3, 16'd40, 16'd39, 32'd1, 32'd9);
        @(negedge clk);
        reset    = 1'b1;
        m_active = 1'b0;
        m_drain  = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        // Recovery anchor: 3+1 does not beat W=7
        send_beat(1, 1, 0, 32'd7, 16'd41, 16'd40, 32'd1, 32'd3);
        idle(4);

        check("sb_empty", sb.size(), 0);
        check("results_count", n_popped, n_pushed);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
